instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives the word address into the synchronous instruction ROM (`instructionmemory`: address registered on `clock`, `q` valid the cycle after).
- Delivers `{instr, instr_pc, instr_valid}` to decode.
- Handles decode-side stall and execute-side branch/jump redirect, and counts retired fetches.

Parameters:
- DATA_WIDTH, 32, instruction width; matches ROM `q`.
- ADDR_WIDTH, 10, ROM word-address width (1024 words).
- PC_WIDTH, 32, byte-address program counter width.
- RESET_VECTOR, 32'h0000_0000, byte PC fetched first after reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  ADDR_WIDTH  word address to ROM; = fetch_addr[ADDR_WIDTH+1:2].
- imem_q  in  DATA_WIDTH  ROM read data; valid the cycle after the address is sampled.
- stall  in  1  decode cannot accept `instr` this cycle.
- redirect  in  1  branch/jump taken; discard current instr, fetch from redirect_target.
- redirect_target  in  PC_WIDTH  byte target; bits [1:0] ignored (forced 0).
- instr  out  DATA_WIDTH  fetched instruction; = imem_q when instr_valid, else 0.
- instr_pc  out  PC_WIDTH  byte PC of `instr`.
- instr_valid  out  1  instr/instr_pc meaningful and offered to decode.
- fetch_count  out  32  number of accepted instructions.

Behaviour:
- State registers: pc (PC of in-flight read), inflight (0/1), fetch_count.
- Reset (synchronous, any cycle including mid-stall or mid-redirect):
  - pc<=RESET_VECTOR, inflight<=0, fetch_count<=0.
  - While reset is high: instr_valid=0, instr=0, instr_pc=pc.
- fetch_addr mux, evaluated in priority order:
  - reset: RESET_VECTOR.
  - redirect: {redirect_target[PC_WIDTH-1:2],2'b00}.
  - !inflight: pc.
  - stall: pc (re-read the same word, so imem_q stays stable).
  - otherwise: pc+4.
- Each non-reset edge: pc<=fetch_addr, inflight<=1.
- instr_valid = inflight & !redirect & !reset.
- Latency:
  - First edge with reset low: ROM samples RESET_VECTOR.
  - The following cycle: instr_valid=1, instr=mem[RESET_VECTOR>>2].
- Throughput: one instruction per cycle when stall=0.
- Accept = instr_valid & !stall. fetch_count increments by 1 on each accept and wraps 2^32-1 -> 0.
- Stall: instr, instr_pc and instr_valid are held constant for the stall duration; no PC advance; no count.
- Redirect:
  - Takes priority over stall.
  - The instruction offered in the redirect cycle is dropped (instr_valid forced 0, not counted).
  - The target instruction is valid the next cycle, giving a 1-cycle penalty.
  - Back-to-back redirects: each cycle drops, and the last target wins.
- Redirect and stall in the same cycle: redirect wins; the stall is ignored for that edge.
- Address wrap:
  - imem_address takes the PC modulo 2^ADDR_WIDTH words.
  - instr_pc keeps the full PC_WIDTH bits.
  - PC arithmetic wraps at 2^PC_WIDTH.
- All arithmetic is unsigned at PC_WIDTH. No combinational path from imem_q to any register input.

Decomposition:
- Shared package holds:
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h0000_0000.
  - RESET_VECTOR default.
  - PC_WIDTH/ADDR_WIDTH defaults, shared with `instructionmemory`.
- No sub-module needed; the next-PC mux plus pc+4 adder stays inline.
- The bench instantiates `instructionmemory` as the real ROM, initialised with word k = 32'h1000_0000+k.

Test Plan:
- Reset 3 cycles, release, stall=0 for 6 cycles:
  - instr_valid rises exactly one cycle after the first non-reset edge.
  - instr = 0x10000000, 0x10000001, ..., 0x10000005.
  - instr_pc = 0x0, 0x4, ..., 0x14.
  - fetch_count = 6.
- Stall held 3 cycles while instr_pc=0x8:
  - instr stays 0x10000002 and instr_valid stays 1 for all 3 cycles.
  - Next cycle instr_pc=0xC.
  - fetch_count increments only once for 0x8.
- redirect=1 with target 0x103 while instr_pc=0x10:
  - That cycle instr_valid=0.
  - Next cycle instr_pc=0x100, instr=0x10000040.
  - 0x10 is not counted.
- redirect and stall both asserted in the same cycle (target 0x20):
  - Redirect wins; next cycle instr_pc=0x20, instr=0x10000008.
- Target 0xFFC sequential run:
  - instr_pc goes 0xFFC -> 0x1000.
  - imem_address goes 0x3FF -> 0x000.
  - instr = 0x100003FF then 0x10000000.
- Reset asserted mid-stall at instr_pc=0x18:
  - instr_valid=0 during reset and fetch_count=0.
  - After release, fetch restarts at 0x0 with 1-cycle latency.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage and the instruction ROM it drives.
package instruction_fetch_pkg;

    localparam int          DATA_WIDTH_DEF   = 32;
    localparam int          ADDR_WIDTH_DEF   = 10;
    localparam int          PC_WIDTH_DEF     = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] ROM_BASE_WORD    = 32'h1000_0000;

endpackage

// File: rtl/instructionmemory.sv
// Synchronous instruction ROM: address registered on clock, q valid the next cycle.
// Contents are the fixed pattern word k = ROM_BASE_WORD + k.
module instructionmemory
    import instruction_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        q <= DATA_WIDTH'(ROM_BASE_WORD) + DATA_WIDTH'(address);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM word address and offers one
// instruction per cycle to decode, with stall hold and redirect flush.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                   DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int                   ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int                   PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_q,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    output logic                  instr_valid,
    output logic [31:0]           fetch_count
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                inflight_q;
    logic [31:0]         count_q, count_d;
    logic                accept;
    logic                unused_bits;

    // pc_d doubles as the fetch address: the ROM samples it on the same edge
    // that pc_q captures it, so pc_q always names the word now on imem_q.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(INSTR_BYTES);
        if (reset)
            pc_d = RESET_VECTOR;
        else if (redirect)
            pc_d = {redirect_target[PC_WIDTH-1:2], 2'b00};
        else if (!inflight_q || stall)
            pc_d = pc_q;
    end

    assign imem_address = pc_d[ADDR_WIDTH+1:2];

    assign instr_valid = inflight_q & ~redirect & ~reset;
    assign accept      = instr_valid & ~stall;
    assign count_d     = count_q + {31'd0, accept};

    assign instr       = instr_valid ? imem_q : DATA_WIDTH'(NOP_INSTR);
    assign instr_pc    = pc_q;
    assign fetch_count = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            inflight_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= 1'b1;
            count_q    <= count_d;
        end
    end

    assign unused_bits = ^{pc_d, redirect_target[1:0]};

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch driving the real instructionmemory ROM; a
// transaction-level model predicts every output each cycle.
module tb_instruction_fetch;

    localparam int          DW = 32;
    localparam int          AW = 10;
    localparam int          PW = 32;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_target = '0;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] imem_q;
    logic [DW-1:0] instr;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic [31:0]   fetch_count;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    instruction_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_WIDTH(PW), .RESET_VECTOR(RV)
    ) dut (
        .clock(clock), .reset(reset), .imem_address(imem_address), .imem_q(imem_q),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fetch_count(fetch_count)
    );

    instructionmemory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rom (
        .clock(clock), .address(imem_address), .q(imem_q)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
        end
    endtask

    // Model: the instruction currently offered is at m_pc (if m_have); the
    // ROM holds word k = 0x10000000 + k, indexed modulo 1024 words.
    logic [31:0] m_pc = '0;
    bit          m_have = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          m_live = 1'b0;

    function automatic logic [31:0] rom_word(input logic [31:0] byte_pc);
        return 32'h1000_0000 + ((byte_pc >> 2) % 1024);
    endfunction

    function automatic logic [31:0] model_next();
        if (reset)                  return RV;
        if (redirect)               return redirect_target & ~32'h3;
        if (!m_have || stall)       return m_pc;
        return m_pc + 32'd4;
    endfunction

    always @(posedge clock) begin
        logic [31:0] nxt;
        if (reset) begin
            m_pc = RV; m_have = 1'b0; m_cnt = '0; m_live = 1'b1;
        end else begin
            nxt = model_next();
            if (m_have && !redirect && !stall) m_cnt = m_cnt + 1;
            m_pc = nxt;
            m_have = 1'b1;
        end
    end

    always @(negedge clock) begin
        logic        ev;
        logic [31:0] na;
        #2;
        if (m_live) begin
            ev = m_have && !redirect && !reset;
            na = (model_next() >> 2) % 1024;
            check("model.valid", 32'(instr_valid), 32'(ev));
            check("model.pc", instr_pc, m_pc);
            check("model.instr", instr, ev ? rom_word(m_pc) : 32'h0);
            check("model.count", fetch_count, m_cnt);
            check("model.addr", 32'(imem_address), na);
        end
    end

    task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] t);
        @(negedge clock);
        reset = r; stall = s; redirect = d; redirect_target = t;
        #3;
    endtask

    initial begin
        repeat (3) begin
            cyc(1, 0, 0, 0);
            check("rst.valid", 32'(instr_valid), 0);
            check("rst.instr", instr, 0);
        end
        cyc(0, 0, 0, 0);
        check("first.valid", 32'(instr_valid), 0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 0);
            check("seq.valid", 32'(instr_valid), 1);
            check("seq.instr", instr, 32'h1000_0000 + k);
            check("seq.pc", instr_pc, 4 * k);
        end
        cyc(0, 0, 1, 32'h8);
        check("seq.count", fetch_count, 6);
        check("redir.valid", 32'(instr_valid), 0);
        repeat (3) begin
            cyc(0, 1, 0, 0);
            check("stall.pc", instr_pc, 32'h8);
            check("stall.instr", instr, 32'h1000_0002);
            check("stall.valid", 32'(instr_valid), 1);
            check("stall.count", fetch_count, 6);
        end
        cyc(0, 0, 0, 0);
        check("unstall.pc", instr_pc, 32'h8);
        cyc(0, 0, 0, 0);
        check("after.pc", instr_pc, 32'hC);
        check("after.count", fetch_count, 7);
        cyc(0, 0, 1, 32'h103);
        check("r103.pc", instr_pc, 32'h10);
        check("r103.valid", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0);
        check("tgt.pc", instr_pc, 32'h100);
        check("tgt.instr", instr, 32'h1000_0040);
        check("tgt.count", fetch_count, 8);
        cyc(0, 1, 1, 32'h20);
        check("rs.valid", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0);
        check("rs.pc", instr_pc, 32'h20);
        check("rs.instr", instr, 32'h1000_0008);
        check("rs.count", fetch_count, 9);
        cyc(0, 0, 1, 32'hFFC);
        check("wrap.addr0", 32'(imem_address), 32'h3FF);
        cyc(0, 0, 0, 0);
        check("wrap.pc0", instr_pc, 32'hFFC);
        check("wrap.instr0", instr, 32'h1000_03FF);
        check("wrap.addr1", 32'(imem_address), 32'h000);
        cyc(0, 0, 0, 0);
        check("wrap.pc1", instr_pc, 32'h1000);
        check("wrap.instr1", instr, 32'h1000_0000);
        cyc(0, 0, 1, 32'h18);
        cyc(0, 1, 0, 0);
        check("mid.pc", instr_pc, 32'h18);
        check("mid.valid", 32'(instr_valid), 1);
        cyc(1, 1, 0, 0);
        check("midrst.valid", 32'(instr_valid), 0);
        check("midrst.instr", instr, 0);
        cyc(1, 0, 0, 0);
        check("midrst.count", fetch_count, 0);
        check("midrst.pc", instr_pc, 32'h0);
        cyc(0, 0, 0, 0);
        check("restart.valid0", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0);
        check("restart.valid1", 32'(instr_valid), 1);
        check("restart.pc", instr_pc, 32'h0);
        check("restart.instr", instr, 32'h1000_0000);

        for (int i = 0; i < 3000; i++) begin
            logic        r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       t = $urandom;
                1:       t = 32'hFFC;
                2:       t = 32'hFFFF_FFF8;
                default: t = $urandom_range(0, 4095);
            endcase
            cyc(r, s, d, t);
        end
        @(negedge clock);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
